// File: rtl/sopc_nios_jtag_sysclk_cmd_bridge.sv
// System-clock side of the Nios II JTAG debug path: synchronises TCK-domain update
// strobes, queues IR/DR commands in a small FWFT FIFO and decodes one-hot actions.
module sopc_nios_jtag_sysclk_cmd_bridge #(
  parameter int DATA_WIDTH  = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [IR_WIDTH-1:0]              ir_in,
  input  logic [DATA_WIDTH-1:0]            sr,
  input  logic                             vs_udr,
  input  logic                             vs_uir,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [IR_WIDTH-1:0]              cmd_ir,
  output logic [DATA_WIDTH-1:0]            cmd_data,
  output logic                             cmd_is_uir,
  output logic [DATA_WIDTH-1:0]            jdo,
  output logic [(2**IR_WIDTH)-1:0]         take_action,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow,
  input  logic                             overflow_clr
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int ACT_W = 2**IR_WIDTH;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync_p0, uir_sync_p0;
  logic                   udr_dly_p1, uir_dly_p1;
  logic                   udr_edge, uir_edge;
  logic                   pending_uir;
  logic                   push, push_uir, push_ok, pop, full;

  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          count;

  logic [IR_WIDTH-1:0]    mem_ir   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic                   mem_uir  [FIFO_DEPTH];

  // Stage p0: synchroniser chains; stage p1: edge flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_p0 <= '0;
      uir_sync_p0 <= '0;
      udr_dly_p1  <= 1'b0;
      uir_dly_p1  <= 1'b0;
    end else begin
      udr_sync_p0 <= {udr_sync_p0[SYNC_STAGES-2:0], vs_udr};
      uir_sync_p0 <= {uir_sync_p0[SYNC_STAGES-2:0], vs_uir};
      udr_dly_p1  <= udr_sync_p0[SYNC_STAGES-1];
      uir_dly_p1  <= uir_sync_p0[SYNC_STAGES-1];
    end
  end

  assign udr_edge = udr_sync_p0[SYNC_STAGES-1] & ~udr_dly_p1;
  assign uir_edge = uir_sync_p0[SYNC_STAGES-1] & ~uir_dly_p1;

  // UDR always owns the single push slot; a colliding UIR waits in pending_uir.
  always_comb begin
    push     = 1'b0;
    push_uir = 1'b0;
    if (udr_edge) begin
      push = 1'b1;
    end else if (uir_edge || pending_uir) begin
      push     = 1'b1;
      push_uir = 1'b1;
    end
  end

  assign full    = (count == FULL_LVL);
  assign pop     = cmd_valid & cmd_ready;
  assign push_ok = push & (~full | pop);

  // Stage p2: FIFO storage, data only, no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_ir[wr_ptr]   <= ir_in;
      mem_data[wr_ptr] <= push_uir ? '0 : sr;
      mem_uir[wr_ptr]  <= push_uir;
    end
  end

  // Stage p2: FIFO control, jdo capture and action decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_uir <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      jdo         <= '0;
      take_action <= '0;
    end else begin
      if (udr_edge && uir_edge)
        pending_uir <= 1'b1;
      else if (!udr_edge)
        pending_uir <= 1'b0;

      if (udr_edge)
        jdo <= sr;

      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase

      if (push && full && !pop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;

      if (pop && !mem_uir[rd_ptr])
        take_action <= ACT_W'(1) << mem_ir[rd_ptr];
      else
        take_action <= '0;
    end
  end

  // Head outputs are forced to zero when empty so stale storage never leaks out.
  assign cmd_valid  = (count != '0);
  assign cmd_ir     = cmd_valid ? mem_ir[rd_ptr]   : '0;
  assign cmd_data   = cmd_valid ? mem_data[rd_ptr] : '0;
  assign cmd_is_uir = cmd_valid ? mem_uir[rd_ptr]  : 1'b0;
  assign fifo_level = count;

endmodule

// File: tb/tb_sopc_nios_jtag_sysclk_cmd_bridge.sv
// Directed bench for the sysclk command bridge (DATA_WIDTH=38, IR_WIDTH=2, SYNC_STAGES=2, depth 4).
module tb_sopc_nios_jtag_sysclk_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr, vs_uir;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        cmd_is_uir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [2:0]  fifo_level;
  logic        overflow, overflow_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sopc_nios_jtag_sysclk_cmd_bridge #(
    .DATA_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .cmd_is_uir(cmd_is_uir), .jdo(jdo),
    .take_action(take_action), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_udr(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ir_in = 2'b00; sr = 38'h0; vs_udr = 1'b1; vs_uir = 1'b0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    tick(3);

    // T1: reset values, then exactly one push from a strobe held through release
    reset_n = 1'b1;
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_outs", {cmd_ir, cmd_is_uir, take_action, overflow}, 64'd0);
    check("rst_data", 64'(cmd_data) | 64'(jdo), 64'd0);
    tick(5);
    vs_udr = 1'b0;
    tick(5);
    check("t1_one_push", 64'(fifo_level), 64'd1);
    pop_one();
    check("t1_action", 64'(take_action), 64'h1);
    check("t1_drained", 64'(fifo_level), 64'd0);

    // T2: single DR update with latency check
    ir_in = 2'b01; sr = 38'h2A_1234_5678; cmd_ready = 1'b1; vs_udr = 1'b1;
    tick(1);
    check("t2_e0_valid", 64'(cmd_valid), 64'd0);
    tick(1);
    check("t2_e1_valid", 64'(cmd_valid), 64'd0);
    tick(1);
    check("t2_e2_valid", 64'(cmd_valid), 64'd1);
    check("t2_data", 64'(cmd_data), 64'h2A_1234_5678);
    check("t2_is_uir", 64'(cmd_is_uir), 64'd0);
    check("t2_jdo", 64'(jdo), 64'h2A_1234_5678);
    vs_udr = 1'b0;
    tick(1);
    check("t2_action", 64'(take_action), 64'h2);
    check("t2_valid_after", 64'(cmd_valid), 64'd0);
    tick(1);
    check("t2_action_end", 64'(take_action), 64'h0);
    cmd_ready = 1'b0;
    tick(3);

    // T3: simultaneous UDR and UIR edges
    ir_in = 2'b11; sr = 38'h15_0F0F_0F0F; vs_udr = 1'b1; vs_uir = 1'b1;
    tick(5);
    vs_udr = 1'b0; vs_uir = 1'b0;
    tick(3);
    check("t3_level", 64'(fifo_level), 64'd2);
    check("t3_head_uir", 64'(cmd_is_uir), 64'd0);
    check("t3_head_data", 64'(cmd_data), 64'h15_0F0F_0F0F);
    pop_one();
    check("t3_action", 64'(take_action), 64'h8);
    check("t3_2nd_uir", 64'(cmd_is_uir), 64'd1);
    check("t3_2nd_ir", 64'(cmd_ir), 64'd3);
    check("t3_2nd_data", 64'(cmd_data), 64'd0);
    pop_one();
    check("t3_uir_no_action", 64'(take_action), 64'h0);
    check("t3_empty", 64'(fifo_level), 64'd0);

    // T4: overflow after five pushes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) pulse_udr(2'(i), 38'h100 + 38'(i));
    check("t4_level", 64'(fifo_level), 64'd4);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_head", 64'(cmd_data), 64'h100);
    check("t4_jdo", 64'(jdo), 64'h104);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("t4_ovf_clr", 64'(overflow), 64'd0);

    // T5: push and pop in the same cycle while full
    ir_in = 2'b10; sr = 38'h3F_DEAD_BEEF; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    check("t5_level", 64'(fifo_level), 64'd4);
    check("t5_no_ovf", 64'(overflow), 64'd0);
    check("t5_head", 64'(cmd_data), 64'h101);
    check("t5_jdo", 64'(jdo), 64'h3F_DEAD_BEEF);
    tick(3);

    // T6: asynchronous reset with a partly filled queue
    pop_one();
    check("t6_level3", 64'(fifo_level), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid", 64'(cmd_valid), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("t6_stays_empty", 64'(fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
